// File: rtl/ifetch_req_queue_pkg.sv
// Purpose: shared widths, wavefront-id tag field and memory FSM encoding for the fetch request queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifetch_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_TAG_W  = 39;
    localparam int DEF_DATA_W = 32;

    // Wavefront id occupies the low bits of the fetch tag.
    localparam int WFID_LSB = 0;
    localparam int WFID_MSB = 5;
    localparam int WFID_W   = WFID_MSB - WFID_LSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_req_queue_if.sv
// Purpose: bundles the fetch request, flush, memory read and instruction return signals of the queue.
// Latency: n/a (wiring only).
// Backpressure: buff_ack acknowledges a held request; mem_rd_en is held until mem_ack.
// Modports: slave = the queue itself, master = the surrounding fetch/memory/wavepool environment.
interface ifetch_req_queue_if
    import ifetch_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              buff_rd_en;
    logic [ADDR_W-1:0] buff_addr;
    logic [TAG_W-1:0]  buff_tag;
    logic              buff_ack;
    logic              flush_en;
    logic [WFID_W-1:0] flush_wfid;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rd_data;
    logic              fetch_instr_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic [TAG_W-1:0]  fetch_instr_tag;
    logic [CNT_W-1:0]  queue_count;
    logic              queue_full;

    modport slave (
        input  buff_rd_en, buff_addr, buff_tag, flush_en, flush_wfid, mem_ack, mem_rd_data,
        output buff_ack, mem_rd_en, mem_addr, fetch_instr_valid, fetch_instr, fetch_instr_tag,
               queue_count, queue_full
    );

    modport master (
        output buff_rd_en, buff_addr, buff_tag, flush_en, flush_wfid, mem_ack, mem_rd_data,
        input  buff_ack, mem_rd_en, mem_addr, fetch_instr_valid, fetch_instr, fetch_instr_tag,
               queue_count, queue_full
    );

endinterface

// File: rtl/ifetch_req_queue_fifo.sv
// Purpose: circular request buffer with per-entry valid bits and parallel wfid-match invalidation.
// Latency: push visible at the head one edge later; head outputs read straight from storage.
// Backpressure: caller must not push when full unless popping on the same edge, nor pop when empty.
// Ports: i_push/i_push_vld/i_push_addr/i_push_tag write side, i_pop read side, i_flush_* invalidation,
//        o_head_* head entry, o_count/o_full occupancy (invalidated entries still count).
module ifetch_req_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAG_W  = DEF_TAG_W
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_push_vld,
    input  logic [ADDR_W-1:0]          i_push_addr,
    input  logic [TAG_W-1:0]           i_push_tag,
    input  logic                       i_pop,
    input  logic                       i_flush_en,
    input  logic [WFID_W-1:0]          i_flush_wfid,
    output logic                       o_head_vld,
    output logic [ADDR_W-1:0]          o_head_addr,
    output logic [TAG_W-1:0]           o_head_tag,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DEPTH-1:0]  r_vld;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [TAG_W-1:0]  r_tag  [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            // Matching entries go invalid in place; unoccupied slots may be cleared too,
            // which is harmless since a push rewrites the bit.
            if (i_flush_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_tag[i][WFID_MSB:WFID_LSB] == i_flush_wfid)
                        r_vld[i] <= 1'b0;
                end
            end
            // Push after flush so a same-edge push carries the caller's already-flushed valid.
            if (i_push) begin
                r_vld[r_wr_ptr] <= i_push_vld;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_tag[r_wr_ptr]  <= i_push_tag;
        end
    end

    assign o_head_vld  = r_vld[r_rd_ptr];
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_tag  = r_tag[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full      = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/ifetch_req_queue.sv
// Purpose: fetch request queue; acks fetch requests, serialises them onto a single-outstanding memory port.
// Latency: enqueue E0 -> mem_rd_en at E1; mem_ack at Ek -> fetch_instr_valid Ek..Ek+1 (3 edges minimum).
// Backpressure: requests wait un-acked while full; one memory read outstanding, held until mem_ack.
// Ports: clk, rst (async active-low), bus (slave modport: request/ack, flush, memory read, instruction return, occupancy).
module ifetch_req_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic               clk,
    input  logic               rst,
    ifetch_req_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ifetch_state_t     r_state;
    logic              r_buff_ack;
    logic              r_mem_rd_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [TAG_W-1:0]  r_tag;
    logic              r_discard;
    logic              r_instr_valid;
    logic [DATA_W-1:0] r_instr;

    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    logic              w_head_vld;
    logic [ADDR_W-1:0] w_head_addr;
    logic [TAG_W-1:0]  w_head_tag;
    logic              w_enq;
    logic              w_enq_vld;
    logic              w_pop;
    logic              w_head_flush;
    logic              w_inflight_flush;

    // While buff_ack is high the request on the bus is the one just taken, still held by fetch.
    assign w_enq     = bus.buff_rd_en && !w_full && !r_buff_ack;
    assign w_enq_vld = !(bus.flush_en && (bus.buff_tag[WFID_MSB:WFID_LSB] == bus.flush_wfid));

    // RESP also pops so the next request starts on the edge that ends the response.
    assign w_pop            = (r_state != REQ) && (w_count != '0);
    assign w_head_flush     = bus.flush_en && (w_head_tag[WFID_MSB:WFID_LSB] == bus.flush_wfid);
    assign w_inflight_flush = bus.flush_en && (r_tag[WFID_MSB:WFID_LSB] == bus.flush_wfid);

    ifetch_req_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .TAG_W  (TAG_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_enq),
        .i_push_vld   (w_enq_vld),
        .i_push_addr  (bus.buff_addr),
        .i_push_tag   (bus.buff_tag),
        .i_pop        (w_pop),
        .i_flush_en   (bus.flush_en),
        .i_flush_wfid (bus.flush_wfid),
        .o_head_vld   (w_head_vld),
        .o_head_addr  (w_head_addr),
        .o_head_tag   (w_head_tag),
        .o_count      (w_count),
        .o_full       (w_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_buff_ack    <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_addr    <= '0;
            r_tag         <= '0;
            r_discard     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
        end else begin
            r_buff_ack    <= w_enq;
            r_instr_valid <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_pop && w_head_vld) begin
                        r_mem_addr  <= w_head_addr;
                        r_tag       <= w_head_tag;
                        // A flush on the pop edge misses the fifo copy, so catch it here.
                        r_discard   <= w_head_flush;
                        r_mem_rd_en <= 1'b1;
                        r_state     <= REQ;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                REQ: begin
                    if (w_inflight_flush)
                        r_discard <= 1'b1;
                    if (bus.mem_ack) begin
                        r_mem_rd_en   <= 1'b0;
                        r_instr       <= bus.mem_rd_data;
                        r_instr_valid <= !(r_discard || w_inflight_flush);
                        r_state       <= RESP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.buff_ack          = r_buff_ack;
    assign bus.mem_rd_en         = r_mem_rd_en;
    assign bus.mem_addr          = r_mem_addr;
    assign bus.fetch_instr_valid = r_instr_valid;
    assign bus.fetch_instr       = r_instr;
    assign bus.fetch_instr_tag   = r_tag;
    assign bus.queue_count       = w_count;
    assign bus.queue_full        = w_full;

endmodule

// File: tb/tb_ifetch_req_queue.sv
// Purpose: directed self-checking bench for ifetch_req_queue; memory responder plus output monitor.
// Latency: inputs driven 1ns after the falling edge, outputs sampled on the falling edge.
// Backpressure: memory acks after mem_wait cycles unless mem_hold stalls it.
module tb_ifetch_req_queue;
    import ifetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifetch_req_queue_if #(.DEPTH(4), .ADDR_W(32), .TAG_W(39), .DATA_W(32)) bus();

    ifetch_req_queue #(.DEPTH(4), .ADDR_W(32), .TAG_W(39), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit mem_hold = 1'b1;
    int mem_wait = 0;

    int          ack_cnt = 0;
    int          last_ack_cyc = 0;
    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];
    logic [38:0] tag_q[$];
    int          vcyc_q[$];
    logic        prev_rd = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [38:0] mk_tag(input int hi, input int wfid);
        return {33'(hi), 6'(wfid)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] a, input logic [38:0] t);
        bit ok;
        ok = 1'b0;
        bus.buff_rd_en = 1'b1;
        bus.buff_addr  = a;
        bus.buff_tag   = t;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (bus.buff_ack) begin
                ok = 1'b1;
                break;
            end
        end
        bus.buff_rd_en = 1'b0;
        chk("req_ack", 64'(ok), 64'd1);
    endtask

    task automatic wait_resps(input int n);
        for (int i = 0; i < 200; i++) begin
            if (instr_q.size() >= n) break;
            tick(1);
        end
        chk("resp_arrived", 64'(instr_q.size() >= n), 64'd1);
    endtask

    // Memory model: word = addr ^ 0xBF810018, so PC 0x18 returns 0xBF810000.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ack     = 1'b0;
        bus.mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end else if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (bus.mem_rd_en && !mem_hold) begin
                if (wcnt >= mem_wait) begin
                    bus.mem_ack     = 1'b1;
                    bus.mem_rd_data = bus.mem_addr ^ 32'hBF81_0018;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.buff_ack) begin
                ack_cnt++;
                last_ack_cyc = cyc;
            end
            if (bus.mem_rd_en && !prev_rd) addr_q.push_back(bus.mem_addr);
            prev_rd = bus.mem_rd_en;
            if (bus.fetch_instr_valid) begin
                instr_q.push_back(bus.fetch_instr);
                tag_q.push_back(bus.fetch_instr_tag);
                vcyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int abase;
        int a0;
        bit ok;
        logic [31:0] ord_addr  [3];
        logic [31:0] ord_instr [3];
        int          ord_wfid  [3];

        bus.buff_rd_en = 1'b0;
        bus.buff_addr  = '0;
        bus.buff_tag   = '0;
        bus.flush_en   = 1'b0;
        bus.flush_wfid = '0;
        tick(3);

        // Reset values
        chk("rst_buff_ack",  64'(bus.buff_ack), 64'd0);
        chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        chk("rst_valid",     64'(bus.fetch_instr_valid), 64'd0);
        chk("rst_count",     64'(bus.queue_count), 64'd0);
        chk("rst_full",      64'(bus.queue_full), 64'd0);
        chk("rst_mem_addr",  64'(bus.mem_addr), 64'd0);
        chk("rst_instr",     64'(bus.fetch_instr), 64'd0);
        chk("rst_tag",       64'(bus.fetch_instr_tag), 64'd0);
        rst = 1'b1;
        tick(2);

        // Single request, two memory wait cycles
        mem_hold = 1'b0;
        mem_wait = 2;
        send_req(32'h18, mk_tag(1, 2));
        wait_resps(1);
        tick(5);
        chk("single_ack_cnt", 64'(ack_cnt), 64'd1);
        chk("single_nreads",  64'(addr_q.size()), 64'd1);
        chk("single_addr",    64'(addr_q[0]), 64'h18);
        chk("single_nresp",   64'(instr_q.size()), 64'd1);
        chk("single_instr",   64'(instr_q[0]), 64'hBF81_0000);
        chk("single_tag",     64'(tag_q[0]), 64'(mk_tag(1, 2)));

        // Ordering across wavefronts
        mem_wait = 1;
        base = instr_q.size();
        ord_addr  = '{32'h0, 32'h4, 32'h20};
        ord_instr = '{32'hBF81_0018, 32'hBF81_001C, 32'hBF81_0038};
        ord_wfid  = '{0, 1, 0};
        for (int k = 0; k < 3; k++) send_req(ord_addr[k], mk_tag(10 + k, ord_wfid[k]));
        wait_resps(base + 3);
        tick(3);
        chk("order_nresp", 64'(instr_q.size()), 64'(base + 3));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("order_instr%0d", k), 64'(instr_q[base + k]), 64'(ord_instr[k]));
            chk($sformatf("order_tag%0d", k),   64'(tag_q[base + k]),   64'(mk_tag(10 + k, ord_wfid[k])));
        end

        // Fill: one read stalled in flight, four queued, fifth waits for a pop
        mem_hold = 1'b1;
        base = instr_q.size();
        send_req(32'h200, mk_tag(2, 4));
        tick(2);
        for (int k = 0; k < 4; k++) send_req(32'h204 + 32'(4 * k), mk_tag(2, 5 + k));
        tick(1);
        chk("fill_count", 64'(bus.queue_count), 64'd4);
        chk("fill_full",  64'(bus.queue_full), 64'd1);
        a0 = ack_cnt;
        bus.buff_rd_en = 1'b1;
        bus.buff_addr  = 32'h214;
        bus.buff_tag   = mk_tag(2, 9);
        tick(4);
        chk("fill_held_no_ack", 64'(ack_cnt), 64'(a0));
        mem_hold = 1'b0;
        mem_wait = 0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bus.buff_ack) begin
                ok = 1'b1;
                break;
            end
        end
        bus.buff_rd_en = 1'b0;
        chk("fill_late_ack", 64'(ok), 64'd1);
        chk("fill_ack_after_resp", 64'(last_ack_cyc > vcyc_q[base]), 64'd1);
        wait_resps(base + 6);
        tick(3);
        chk("fill_nresp",  64'(instr_q.size()), 64'(base + 6));
        chk("fill_last_tag",   64'(tag_q[base + 5]), 64'(mk_tag(2, 9)));
        chk("fill_last_instr", 64'(instr_q[base + 5]), 64'hBF81_020C);
        chk("fill_drained", 64'(bus.queue_count), 64'd0);

        // Flush of queued entries
        mem_hold = 1'b1;
        base  = instr_q.size();
        abase = addr_q.size();
        send_req(32'h100, mk_tag(3, 3));
        tick(2);
        send_req(32'h0,  mk_tag(3, 0));
        send_req(32'h4,  mk_tag(3, 1));
        send_req(32'h20, mk_tag(3, 0));
        tick(1);
        chk("fq_count", 64'(bus.queue_count), 64'd3);
        bus.flush_en   = 1'b1;
        bus.flush_wfid = 6'd0;
        tick(1);
        bus.flush_en   = 1'b0;
        chk("fq_count_kept", 64'(bus.queue_count), 64'd3);
        mem_hold = 1'b0;
        mem_wait = 1;
        wait_resps(base + 2);
        tick(10);
        chk("fq_nresp",  64'(instr_q.size()), 64'(base + 2));
        chk("fq_tag0",   64'(tag_q[base]),     64'(mk_tag(3, 3)));
        chk("fq_tag1",   64'(tag_q[base + 1]), 64'(mk_tag(3, 1)));
        chk("fq_instr1", 64'(instr_q[base + 1]), 64'hBF81_001C);
        chk("fq_nreads", 64'(addr_q.size()), 64'(abase + 2));
        chk("fq_addr1",  64'(addr_q[abase + 1]), 64'h4);
        chk("fq_empty",  64'(bus.queue_count), 64'd0);

        // Flush of an in-flight read
        mem_hold = 1'b1;
        mem_wait = 0;
        base = instr_q.size();
        send_req(32'h40, mk_tag(4, 0));
        tick(2);
        chk("fi_in_req", 64'(bus.mem_rd_en), 64'd1);
        bus.flush_en   = 1'b1;
        bus.flush_wfid = 6'd0;
        tick(1);
        bus.flush_en   = 1'b0;
        mem_hold = 1'b0;
        tick(10);
        chk("fi_suppressed", 64'(instr_q.size()), 64'(base));
        chk("fi_idle",       64'(bus.mem_rd_en), 64'd0);
        send_req(32'h44, mk_tag(4, 1));
        wait_resps(base + 1);
        chk("fi_next_tag",   64'(tag_q[base]),   64'(mk_tag(4, 1)));
        chk("fi_next_instr", 64'(instr_q[base]), 64'hBF81_005C);

        // Flush arriving on the mem_ack edge
        mem_hold = 1'b1;
        base = instr_q.size();
        send_req(32'h60, mk_tag(5, 7));
        tick(2);
        mem_hold = 1'b0;
        tick(1);
        bus.flush_en   = 1'b1;
        bus.flush_wfid = 6'd7;
        tick(1);
        bus.flush_en   = 1'b0;
        tick(8);
        chk("fa_suppressed", 64'(instr_q.size()), 64'(base));
        chk("fa_idle",       64'(bus.mem_rd_en), 64'd0);

        // Reset during REQ with two entries queued
        mem_hold = 1'b1;
        send_req(32'h300, mk_tag(6, 1));
        tick(2);
        send_req(32'h304, mk_tag(6, 2));
        send_req(32'h308, mk_tag(6, 3));
        tick(1);
        chk("mr_pre_count", 64'(bus.queue_count), 64'd2);
        chk("mr_pre_rd_en", 64'(bus.mem_rd_en), 64'd1);
        rst = 1'b0;
        #1;
        chk("mr_buff_ack",  64'(bus.buff_ack), 64'd0);
        chk("mr_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        chk("mr_valid",     64'(bus.fetch_instr_valid), 64'd0);
        chk("mr_count",     64'(bus.queue_count), 64'd0);
        chk("mr_full",      64'(bus.queue_full), 64'd0);
        chk("mr_mem_addr",  64'(bus.mem_addr), 64'd0);
        chk("mr_instr",     64'(bus.fetch_instr), 64'd0);
        chk("mr_tag",       64'(bus.fetch_instr_tag), 64'd0);
        tick(2);
        rst = 1'b1;
        mem_hold = 1'b0;
        mem_wait = 0;
        tick(2);
        chk("mr_post_count", 64'(bus.queue_count), 64'd0);
        base = instr_q.size();
        send_req(32'h18, mk_tag(7, 2));
        wait_resps(base + 1);
        tick(5);
        chk("mr_post_nresp",   64'(instr_q.size()), 64'(base + 1));
        chk("mr_post_instr",   64'(instr_q[base]), 64'hBF81_0000);
        chk("mr_post_tag",     64'(tag_q[base]), 64'(mk_tag(7, 2)));
        chk("mr_post_latency", 64'(vcyc_q[base] - last_ack_cyc), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
